// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM states and the {N,Z,C,V} flag layout
// used by both the multiplier and the condition unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // cv carries {C,V} straight through; the multiplier never computes them
  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic [1:0] cv);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = cv[1];
    f[FLAG_V] = cv[0];
    return f;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier and step
// counter. Reports when the next shifted multiplier is empty or the count ends.
module mul_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_c,
  output logic [WIDTH-1:0] acc_next,
  output logic             mplier_next_zero,
  output logic             cnt_last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_sum_s;

  // Conditional add of the current multiplicand, wrapping modulo 2^WIDTH
  always_comb begin
    acc_sum_s = acc_r + mcand_r;
    if (mplier_r[0]) begin
      acc_next = acc_sum_s;
    end else begin
      acc_next = acc_r;
    end
  end

  assign mplier_next_zero = (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
  assign cnt_last         = (cnt_r == CNT_W'(WIDTH - 1));

  // Operand load on accept, one shift-add per RUN cycle, hold otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (load) begin
      acc_r    <= accumulate ? src_c : {WIDTH{1'b0}};
      mcand_r  <= src_a;
      mplier_r <= src_b;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (step) begin
      acc_r    <= acc_next;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

endmodule

// File: rtl/mul_flag_unit.sv
// Iterative MUL/MLA unit for the execute stage: control FSM plus registered
// Result/ALUFlags consumed by the condition unit on Done.
module mul_flag_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Accumulate,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] SrcC,
  input  logic [3:0]       FlagsIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  mul_state_t       state_r;
  mul_state_t       state_next_s;
  logic             load_s;
  logic             step_s;
  logic             finish_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       flags_r;
  logic [1:0]       cv_r;
  logic [WIDTH-1:0] acc_next_s;
  logic             mplier_next_zero_s;
  logic             cnt_last_s;
  logic             unused_nz_s;

  // N and Z come from the product; only C and V are taken from FlagsIn
  assign unused_nz_s = ^FlagsIn[3:2];

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk              (clk),
    .reset            (reset),
    .load             (load_s),
    .step             (step_s),
    .accumulate       (Accumulate),
    .src_a            (SrcA),
    .src_b            (SrcB),
    .src_c            (SrcC),
    .acc_next         (acc_next_s),
    .mplier_next_zero (mplier_next_zero_s),
    .cnt_last         (cnt_last_s)
  );

  // Next-state and datapath control; Start is only honoured in IDLE or DONE
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (mplier_next_zero_s || cnt_last_s) begin
          state_next_s = DONE;
          finish_s     = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register with Busy/Done decoded ahead so they leave a flop directly
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Carry/overflow captured at accept time and passed through unchanged
  always_ff @(posedge clk) begin
    if (!reset) begin
      cv_r <= 2'b00;
    end else if (load_s) begin
      cv_r <= FlagsIn[1:0];
    end else begin
      cv_r <= cv_r;
    end
  end

  // Result and flags update only on the exit edge and hold until the next one
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_r <= {WIDTH{1'b0}};
      flags_r  <= 4'b0000;
    end else if (finish_s) begin
      result_r <= acc_next_s;
      flags_r  <= pack_flags(acc_next_s[WIDTH-1], (acc_next_s == {WIDTH{1'b0}}), cv_r);
    end else begin
      result_r <= result_r;
      flags_r  <= flags_r;
    end
  end

  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Result   = result_r;
  assign ALUFlags = flags_r;

endmodule

// File: tb/tb_mul_flag_unit.sv
// Scoreboard bench for mul_flag_unit: the driver predicts each accepted
// operation with plain arithmetic; a negedge monitor checks Busy/Done/Result.
module tb_mul_flag_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic         Accumulate;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [W-1:0] SrcC;
  logic [3:0]   FlagsIn;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic [3:0]   ALUFlags;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           done_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t held;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   free_at = 0;
  bit   mon_en  = 1'b0;

  mul_flag_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Accumulate (Accumulate),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .SrcC       (SrcC),
    .FlagsIn    (FlagsIn),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one Start cycle; if the model says the unit is free, predict the outcome
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic acc, input logic [3:0] f);
    exp_t        e;
    int          k;
    logic [63:0] full;
    Start = 1'b1; SrcA = a; SrcB = b; SrcC = c; Accumulate = acc; FlagsIn = f;
    if (reset && cyc >= free_at) begin
      k = 1;
      for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
      full       = 64'(a) * 64'(b) + (acc ? 64'(c) : 64'd0);
      e.res      = full[W-1:0];
      e.flags    = {e.res[W-1], (e.res == {W{1'b0}}), f[1:0]};
      e.done_cyc = cyc + 1 + k;
      busy_lo    = cyc + 1;
      busy_hi    = cyc + k;
      free_at    = e.done_cyc;
      sbq.push_back(e);
    end
    tick();
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; SrcC = $urandom;
    Accumulate = 1'($urandom); FlagsIn = 4'($urandom);
  endtask

  task automatic wait_free();
    int n = 0;
    while (cyc < free_at && n < 200) begin
      tick();
      n++;
    end
    if (cyc < free_at) check("wait_free_timeout", 64'(cyc), 64'(free_at));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    sbq.delete();
    held.res   = {W{1'b0}};
    held.flags = 4'b0000;
    busy_lo    = 1;
    busy_hi    = 0;
    free_at    = 0;
    reset      = 1'b1;
  endtask

  // Monitor: compares every cycle against the scoreboard and the held values
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy_done_excl", 64'(Busy && Done), 64'd0);
      check("busy", 64'(Busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      if (Done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'(Done), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("result", 64'(Result), 64'(e.res));
          check("aluflags", 64'(ALUFlags), 64'(e.flags));
          held = e;
        end
      end else begin
        check("result_held", 64'(Result), 64'(held.res));
        check("flags_held", 64'(ALUFlags), 64'(held.flags));
        if (sbq.size() != 0 && cyc > sbq[0].done_cyc) begin
          check("missing_done", 64'(cyc), 64'(sbq[0].done_cyc));
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Start = 1'b0; Accumulate = 1'b0;
    SrcA = '0; SrcB = '0; SrcC = '0; FlagsIn = 4'b0000;
    held.res = '0; held.flags = 4'b0000; held.done_cyc = 0;
    tick();
    mon_en = 1'b1;
    // Start while reset is low must be ignored
    issue(32'd3, 32'd5, 32'd0, 1'b0, 4'b0011);
    reset = 1'b1;
    tick();

    issue(32'd3, 32'd5, 32'd0, 1'b0, 4'b0011);
    wait_free(); tick(); tick();
    issue(32'd7, 32'd0, 32'd9, 1'b1, 4'b0000);
    wait_free(); tick();
    issue(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'b0000);
    wait_free(); tick();
    issue(32'h8000_0000, 32'd2, 32'd0, 1'b0, 4'b0000);
    wait_free(); tick();
    issue(32'd1, 32'h8000_0000, 32'd0, 1'b0, 4'b0010);
    wait_free(); tick();

    // Start pulses during RUN are dropped
    issue(32'h0000_1234, 32'h0000_00FF, 32'd100, 1'b1, 4'b0001);
    tick();
    issue(32'd99, 32'd99, 32'd0, 1'b0, 4'b1111);
    issue(32'd7, 32'd7, 32'd0, 1'b0, 4'b1111);
    // Back-to-back: wait_free returns in the Done cycle
    wait_free();
    issue(32'h0001_0001, 32'h0000_0F0F, 32'd0, 1'b0, 4'b0011);
    wait_free();
    issue(32'hDEAD_BEEF, 32'd3, 32'h1111_1111, 1'b1, 4'b0000);
    wait_free(); tick();

    // Abort a 10-cycle run two cycles in
    issue(32'd5, 32'h0000_0200, 32'd0, 1'b0, 4'b0011);
    tick();
    do_reset();
    repeat (14) tick();

    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap == 0) wait_free();
      else repeat (gap) tick();
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
      end else begin
        issue($urandom, $urandom >> $urandom_range(0, 31), $urandom,
              1'($urandom), 4'($urandom));
      end
    end

    wait_free();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_flag_unit.md
# mul_flag_unit

Iterative shift-add multiplier (MUL/MLA) for the pipelined CPU's execute stage. It produces the low WIDTH bits of SrcA*SrcB (+SrcC) and a 4-bit ALUFlags word in the same {N,Z,C,V} layout the condition unit consumes. It is the producer end of the flags path: the condition unit samples its ALUFlags when Done is high. The hazard unit stalls the pipeline while Busy is high.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥ 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets the block)
- Start  in  1  request; sampled only in IDLE or DONE
- Accumulate  in  1  1 = MLA (add SrcC), 0 = MUL; sampled with Start
- SrcA  in  WIDTH  multiplicand
- SrcB  in  WIDTH  multiplier
- SrcC  in  WIDTH  accumulator addend
- FlagsIn  in  4  current {N,Z,C,V}; C,V sampled with Start
- Busy  out  1  high in RUN; stall request
- Done  out  1  one-cycle pulse, Result/ALUFlags valid
- Result  out  WIDTH  product, registered, held until next completion
- ALUFlags  out  4  {N,Z,C,V}, registered, held with Result

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + Start=1 → RUN, loading:
  - acc = Accumulate ? SrcC : 0
  - mcand = SrcA
  - mplier = SrcB
  - cnt = 0
  - cv = FlagsIn[1:0]
- IDLE/DONE + Start=0: DONE → IDLE; IDLE stays IDLE.
- RUN, each cycle:
  - if mplier[0], acc += mcand (mod 2^WIDTH)
  - mcand <<= 1 (bits shifted out are dropped)
  - mplier >>= 1
  - cnt++
- RUN exit → DONE when the shifted mplier == 0 or cnt == WIDTH-1. On the exit edge, load Result = final acc and ALUFlags = {acc[WIDTH-1], acc==0, cv}.
- DONE lasts exactly one cycle unless Start=1 (back-to-back accepted).
- Start in RUN is ignored; the operation is not restarted and no request is queued.
- Arithmetic: all sums modulo 2^WIDTH. Unsigned/signed results are identical in the low WIDTH bits, so there is no sign handling. C and V are never computed and always pass through from FlagsIn.
- Operand inputs are don't-care except in the Start cycle.

## Timing
- Reset values:
  - state = IDLE
  - Busy = 0
  - Done = 0
  - Result = 0
  - ALUFlags = 4'b0000
  - all internal registers = 0
- Reset wins over Start in the same cycle. Reset during RUN aborts: there is no Done pulse and Result is cleared.
- Start accepted at edge t. RUN lasts k cycles, k = max(1, index of the highest set bit of SrcB + 1), k ≤ WIDTH.
  - Busy = 1 for cycles t+1 .. t+k.
  - Done = 1 in cycle t+k+1, with Result/ALUFlags already valid.
- SrcB = 0 → k = 1; Result = acc initial value.
- Back-to-back: Start asserted during Done is accepted. Busy rises the next cycle and Result holds the previous value until the new completion.
- Busy and Done are never high together.

## Structure
- Shared package cpu_pkg holds:
  - the state enum mul_state_t {IDLE, RUN, DONE}
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, shared with the condition unit
- One natural sub-module: mul_datapath, holding the acc/mcand/mplier/cnt registers plus adder and shifters. It takes load/step controls and returns mplier_next_zero and cnt_last.
- The FSM and output registers stay in the top module.

## Test plan
- SrcA=3, SrcB=5, Accumulate=0, FlagsIn=4'b0011, Start at t → Busy high t+1..t+3; Done at t+4; Result=15; ALUFlags=4'b0011.
- SrcA=7, SrcB=0, SrcC=9, Accumulate=1 → k=1; Done at t+2; Result=9; ALUFlags=4'b0000.
- SrcA=32'hFFFFFFFF, SrcB=2, FlagsIn=0 → Done at t+3; Result=32'hFFFFFFFE; ALUFlags=4'b1000.
- Two cases:
  - SrcA=32'h80000000, SrcB=2 → Result=0, ALUFlags=4'b0100 (wrap).
  - SrcB=32'h80000000, SrcA=1 → k=32; Done at t+33; Result=32'h80000000.
- Start pulses during RUN → ignored; the single Done and Result match the first operands. Start during the Done cycle → second operation runs, and Result holds the old value until its Done.
- reset=0 at cycle t+2 of a 10-cycle RUN → next cycle Busy=0, Done=0, Result=0, ALUFlags=0; no Done follows.
